// File: rtl/pe_cell_pkg.sv
// Shared definitions for the PE cell sequencer: FSM encoding, reuse-field layout and
// accumulate-mode constants, plus small field-decode helpers.
package pe_cell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } pe_state_t;

    localparam int REUSE_PASS_HI = 7;
    localparam int REUSE_PASS_LO = 3;
    localparam int REUSE_OUT_EN  = 2;
    localparam int REUSE_MODE_HI = 1;
    localparam int REUSE_MODE_LO = 0;

    localparam logic [1:0] MODE_FIRST = 2'b00;
    localparam logic [1:0] MODE_EVERY = 2'b01;

    // A programmed pass count of zero still runs one pass.
    function automatic logic [4:0] pass_count(input logic [7:0] reuse);
        logic [4:0] p;
        p = reuse[REUSE_PASS_HI:REUSE_PASS_LO];
        return (p == 5'd0) ? 5'd1 : p;
    endfunction

    // Reserved modes 2'b1x fall back to clear-on-first-pass.
    function automatic logic [1:0] eff_mode(input logic [1:0] mode);
        return mode[1] ? MODE_FIRST : mode;
    endfunction

endpackage

// File: rtl/pe_cell_cyc_cnt.sv
// Loadable, clearable MAC-cycle counter with a full-width terminal-count compare.
module pe_cell_cyc_cnt #(
    parameter int WID_CYC = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [WID_CYC-1:0] load_val,
    input  logic               inc,
    input  logic [WID_CYC-1:0] term,
    output logic [WID_CYC-1:0] cnt,
    output logic               tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + WID_CYC'(1);
        end
    end

    // Exact compare against N-1, so the largest count never needs to wrap.
    assign tc = (cnt == term);

endmodule

// File: rtl/pe_cell_seq_ctrl.sv
// Pass sequencer for a PE row: LOAD -> RUN(N) -> DRAIN per pass, FIN after the last pass.
// Every output comes straight from a flop; next values are derived from the next state.
module pe_cell_seq_ctrl
    import pe_cell_pkg::*;
#(
    parameter int WID_CYC   = 32,
    parameter int DRAIN_LAT = 2,
    parameter int DLY       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WID_CYC-1:0] reg_set_cycle,
    input  logic [7:0]         reg_reuse,
    input  logic               alarm_clr,
    output logic               busy,
    output logic               load_en,
    output logic               mac_en,
    output logic               acc_clr,
    output logic               acc_vld,
    output logic               done,
    output logic [4:0]         pass_idx,
    output logic [WID_CYC-1:0] cycle_cnt,
    output logic [7:0]         alarm
);

    if (DRAIN_LAT < 1 || DRAIN_LAT > 15 || DLY < 0) begin : g_param_chk
        $error("pe_cell_seq_ctrl: DRAIN_LAT must be 1..15 and DLY non-negative");
    end

    localparam logic [3:0] DRAIN_TERM = 4'(DRAIN_LAT - 1);

    pe_state_t          state, state_nxt;
    logic [WID_CYC-1:0] set_cycle_sh;
    logic [7:0]         reuse_sh;
    logic [3:0]         drain_cnt, drain_nxt;
    logic [4:0]         pass_nxt;
    logic [3:0]         alarm_r, alarm_set;
    logic [1:0]         mode_nxt;
    logic               start_ok, run_tc, drain_last, last_pass;
    logic               cnt_clr, cnt_ld, cnt_inc;
    logic               acc_clr_nxt, acc_vld_nxt;

    assign start_ok   = (state == ST_IDLE) && start && (reg_set_cycle != '0);
    assign drain_last = (drain_cnt == DRAIN_TERM);
    assign last_pass  = (pass_idx == pass_count(reuse_sh) - 5'd1);

    always_comb begin
        state_nxt = state;
        alarm_set = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (reg_set_cycle != '0) begin
                        state_nxt    = ST_LOAD;
                        alarm_set[3] = reg_reuse[REUSE_MODE_HI];
                    end else begin
                        alarm_set[0] = 1'b1;
                    end
                end
            end
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN:   if (run_tc) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = last_pass ? ST_FIN : ST_LOAD;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Abort and late starts only matter once a run is in flight.
        if (state != ST_IDLE) begin
            if (abort) begin
                state_nxt    = ST_IDLE;
                alarm_set[1] = 1'b1;
            end
            if (start) begin
                alarm_set[2] = 1'b1;
            end
        end
    end

    always_comb begin
        pass_nxt  = pass_idx;
        drain_nxt = '0;
        if (state_nxt == ST_IDLE) begin
            pass_nxt = '0;
        end else if (state == ST_DRAIN && state_nxt == ST_LOAD) begin
            pass_nxt = pass_idx + 5'd1;
        end
        if (state == ST_DRAIN && state_nxt == ST_DRAIN) begin
            drain_nxt = drain_cnt + 4'd1;
        end
        // The first LOAD is decided before the shadow copy exists.
        mode_nxt    = start_ok ? eff_mode(reg_reuse[REUSE_MODE_HI:REUSE_MODE_LO])
                               : eff_mode(reuse_sh[REUSE_MODE_HI:REUSE_MODE_LO]);
        acc_clr_nxt = (state_nxt == ST_LOAD) &&
                      ((mode_nxt == MODE_EVERY) || (pass_nxt == 5'd0));
        acc_vld_nxt = (state_nxt == ST_DRAIN) && (drain_nxt == DRAIN_TERM) &&
                      (reuse_sh[REUSE_OUT_EN] || last_pass);
        cnt_ld      = (state == ST_LOAD) && (state_nxt == ST_RUN);
        cnt_inc     = (state == ST_RUN) && (state_nxt == ST_RUN);
        cnt_clr     = !(cnt_ld || cnt_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cycle_sh <= '0;
            reuse_sh     <= '0;
            pass_idx     <= '0;
            drain_cnt    <= '0;
            busy         <= 1'b0;
            load_en      <= 1'b0;
            mac_en       <= 1'b0;
            acc_clr      <= 1'b0;
            acc_vld      <= 1'b0;
            done         <= 1'b0;
            alarm_r      <= '0;
        end else begin
            if (start_ok) begin
                set_cycle_sh <= reg_set_cycle;
                reuse_sh     <= reg_reuse;
            end
            pass_idx  <= pass_nxt;
            drain_cnt <= drain_nxt;
            busy      <= (state_nxt != ST_IDLE);
            load_en   <= (state_nxt == ST_LOAD);
            mac_en    <= (state_nxt == ST_RUN);
            acc_clr   <= acc_clr_nxt;
            acc_vld   <= acc_vld_nxt;
            done      <= (state_nxt == ST_FIN);
            // A set event in the same cycle as a clear survives.
            alarm_r   <= (alarm_clr ? 4'd0 : alarm_r) | alarm_set;
        end
    end

    assign alarm = {4'b0000, alarm_r};

    pe_cell_cyc_cnt #(
        .WID_CYC (WID_CYC)
    ) u_cyc_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_ld),
        .load_val ('0),
        .inc      (cnt_inc),
        .term     (set_cycle_sh - WID_CYC'(1)),
        .cnt      (cycle_cnt),
        .tc       (run_tc)
    );

endmodule

// File: tb/tb_pe_cell_seq_ctrl.sv
// Bench for pe_cell_seq_ctrl: a schedule-based model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_pe_cell_seq_ctrl;

    localparam int W  = 32;
    localparam int DL = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, alarm_clr;
    logic [W-1:0] reg_set_cycle;
    logic [7:0]   reg_reuse;
    logic         busy, load_en, mac_en, acc_clr, acc_vld, done;
    logic [4:0]   pass_idx;
    logic [W-1:0] cycle_cnt;
    logic [7:0]   alarm;

    int n_checks = 0;
    int n_errors = 0;

    pe_cell_seq_ctrl #(.WID_CYC(W), .DRAIN_LAT(DL), .DLY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .reg_set_cycle(reg_set_cycle), .reg_reuse(reg_reuse), .alarm_clr(alarm_clr),
        .busy(busy), .load_en(load_en), .mac_en(mac_en), .acc_clr(acc_clr),
        .acc_vld(acc_vld), .done(done), .pass_idx(pass_idx), .cycle_cnt(cycle_cnt),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted start expands into the full cycle-by-cycle schedule.
    typedef struct packed {
        logic       busy, load_en, mac_en, acc_clr, acc_vld, done, chk_cnt;
        logic [4:0] pass;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic [7:0] m_alarm = 8'h00;

    function automatic exp_t idle_exp();
        exp_t e = '0;
        e.chk_cnt = 1'b1;
        return e;
    endfunction

    task automatic build(input int n, input logic [7:0] reuse);
        int   np;
        logic every;
        exp_t e;
        np    = (reuse[7:3] == 0) ? 1 : int'(reuse[7:3]);
        every = (reuse[1:0] == 2'b01);
        for (int p = 0; p < np; p++) begin
            e = '0; e.busy = 1; e.load_en = 1; e.acc_clr = every || (p == 0); e.pass = 5'(p);
            q.push_back(e);
            for (int i = 0; i < n; i++) begin
                e = '0; e.busy = 1; e.mac_en = 1; e.chk_cnt = 1; e.cnt = 32'(i); e.pass = 5'(p);
                q.push_back(e);
            end
            for (int d = 0; d < DL; d++) begin
                e = '0; e.busy = 1; e.pass = 5'(p);
                e.acc_vld = (d == DL - 1) && (reuse[2] || (p == np - 1));
                q.push_back(e);
            end
        end
        e = '0; e.busy = 1; e.done = 1; e.pass = 5'(np - 1);
        q.push_back(e);
    endtask

    initial cur = idle_exp();

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] set;
        if (!rst_n) begin
            q.delete();
            cur     = idle_exp();
            m_alarm = 8'h00;
        end else begin
            set = 8'h00;
            if (!cur.busy) begin
                if (start && reg_set_cycle != 0) begin
                    build(int'(reg_set_cycle), reg_reuse);
                    set[3] = reg_reuse[1];
                end else if (start) begin
                    set[0] = 1'b1;
                end
            end else begin
                if (abort) begin
                    q.delete();
                    set[1] = 1'b1;
                end
                if (start) set[2] = 1'b1;
            end
            m_alarm = (alarm_clr ? 8'h00 : m_alarm) | set;
            cur = (q.size() != 0) ? q.pop_front() : idle_exp();
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("load_en", 32'(load_en), 32'(cur.load_en));
        chk("mac_en", 32'(mac_en), 32'(cur.mac_en));
        chk("acc_clr", 32'(acc_clr), 32'(cur.acc_clr));
        chk("acc_vld", 32'(acc_vld), 32'(cur.acc_vld));
        chk("done", 32'(done), 32'(cur.done));
        chk("pass_idx", 32'(pass_idx), 32'(cur.pass));
        chk("alarm", 32'(alarm), 32'(m_alarm));
        if (cur.chk_cnt) chk("cycle_cnt", cycle_cnt, cur.cnt);
    end

    // Per-scenario capture of the strobes for the hand-computed checks.
    logic       lg_clr [64];
    logic [4:0] lg_pass[64];
    int c_busy, c_load, c_mac, c_clr, c_vld, c_done, i_vld, i_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int n, input int inj);
        c_busy = 0; c_load = 0; c_mac = 0; c_clr = 0; c_vld = 0; c_done = 0;
        i_vld = -1; i_done = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lg_clr[i]  = acc_clr;
            lg_pass[i] = pass_idx;
            c_busy += int'(busy); c_load += int'(load_en); c_mac += int'(mac_en);
            c_clr  += int'(acc_clr); c_vld += int'(acc_vld); c_done += int'(done);
            if (acc_vld && i_vld < 0) i_vld = i + 1;
            if (done && i_done < 0) i_done = i + 1;
            if (i == inj) begin
                start = 1'b1;
                reg_set_cycle = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic launch(input logic [31:0] n, input logic [7:0] reuse);
        reg_set_cycle = n;
        reg_reuse     = reuse;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; alarm_clr = 1'b0;
        reg_set_cycle = '0; reg_reuse = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_alarm", 32'(alarm), 32'd0);

        // Zero-length start is rejected and flagged.
        tick();
        launch(32'd0, 8'h09);
        capture(4, -1);
        chk("zero_no_busy", 32'(c_busy), 32'd0);
        chk("zero_alarm", 32'(alarm), 32'h01);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        @(negedge clk);
        chk("alarm_cleared", 32'(alarm), 32'h00);

        // N=3, one pass, clear every pass.
        tick();
        launch(32'd3, 8'h09);
        capture(10, -1);
        chk("p1_busy", 32'(c_busy), 32'd7);
        chk("p1_load", 32'(c_load), 32'd1);
        chk("p1_mac", 32'(c_mac), 32'd3);
        chk("p1_clr_with_load", 32'(lg_clr[0]), 32'd1);
        chk("p1_vld_cycle", 32'(i_vld), 32'd6);
        chk("p1_done_cycle", 32'(i_done), 32'd7);

        // N=2, three passes, per-pass output, clear on first pass only.
        launch(32'd2, 8'h1C);
        capture(20, -1);
        chk("p3_busy", 32'(c_busy), 32'd16);
        chk("p3_clr", 32'(c_clr), 32'd1);
        chk("p3_vld", 32'(c_vld), 32'd3);
        chk("p3_pass0", 32'(lg_pass[0]), 32'd0);
        chk("p3_pass1", 32'(lg_pass[5]), 32'd1);
        chk("p3_pass2", 32'(lg_pass[10]), 32'd2);

        // P=0 runs once; mode 2'b10 flags alarm[3]; P=2 mode 2'b11 reports only at the end.
        launch(32'd1, 8'h00);
        capture(8, -1);
        chk("p0_busy", 32'(c_busy), 32'd5);
        launch(32'd1, 8'h0A);
        capture(8, -1);
        chk("mode1x_alarm3", 32'(alarm[3]), 32'd1);
        launch(32'd3, 8'h13);
        capture(16, -1);
        chk("p2m3_busy", 32'(c_busy), 32'd13);
        chk("p2m3_vld", 32'(c_vld), 32'd1);
        chk("p2m3_clr", 32'(c_clr), 32'd1);

        // Abort in RUN at cycle_cnt==1.
        launch(32'd5, 8'h08);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mac_en && cycle_cnt == 1) found = 1'b1;
        end
        chk("abort_reached", 32'(found), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_alarm1", 32'(alarm[1]), 32'd1);
        capture(8, -1);
        chk("abort_no_done", 32'(c_done), 32'd0);
        chk("abort_no_vld", 32'(c_vld), 32'd0);

        // Second start and a new set_cycle mid-run leave the run untouched.
        launch(32'd4, 8'h08);
        capture(14, 2);
        chk("restart_busy", 32'(c_busy), 32'd8);
        chk("restart_mac", 32'(c_mac), 32'd4);
        chk("restart_alarm2", 32'(alarm[2]), 32'd1);

        // Reset pulsed during DRAIN.
        launch(32'd2, 8'h08);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (busy && !mac_en && !load_en && i > 1) found = 1'b1;
        end
        chk("drain_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {busy, load_en, mac_en, acc_clr, acc_vld, done, pass_idx},
            32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        capture(8, -1);
        chk("rst_no_done", 32'(c_done), 32'd0);
        chk("rst_no_busy", 32'(c_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
